// File: rtl/dmem_pkg.sv
// Shared encodings for the byte-enabled MEM-stage data memory: access sizes,
// fault codes, fill/run states and the alignment rule.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_BAD  = 2'd3;

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_MISALIGN = 2'd1;
    localparam logic [1:0] FC_CONFLICT = 2'd2;
    localparam logic [1:0] FC_RANGE    = 2'd3;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Illegal size counts as misaligned so it shares the same fault code.
    function automatic logic isMisaligned(input logic [1:0] accSize, input logic [1:0] lane);
        logic bad;
        case (accSize)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lane[0];
            SZ_WORD: bad = (lane != 2'd0);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte enables / replicated data, and
// load lane selection with sign or zero extension (little-endian lanes).
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  accSize,
    input  logic [1:0]  lane,
    input  logic        ldUnsigned,
    input  logic [31:0] wrData,
    input  logic [31:0] rdWord,
    output logic [3:0]  byteEn,
    output logic [31:0] wrRep,
    output logic [31:0] ldData
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        byteEn = 4'b0000;
        wrRep  = wrData;
        case (accSize)
            SZ_BYTE: begin
                byteEn = 4'b0001 << lane;
                wrRep  = {4{wrData[7:0]}};
            end
            SZ_HALF: begin
                byteEn = lane[1] ? 4'b1100 : 4'b0011;
                wrRep  = {2{wrData[15:0]}};
            end
            SZ_WORD: byteEn = 4'b1111;
            default: byteEn = 4'b0000;
        endcase
    end

    always_comb begin
        case (lane)
            2'd0:    byteSel = rdWord[7:0];
            2'd1:    byteSel = rdWord[15:8];
            2'd2:    byteSel = rdWord[23:16];
            default: byteSel = rdWord[31:24];
        endcase
        halfSel = lane[1] ? rdWord[31:16] : rdWord[15:0];
        case (accSize)
            SZ_BYTE: ldData = ldUnsigned ? {24'd0, byteSel} : {{24{byteSel[7]}}, byteSel};
            SZ_HALF: ldData = ldUnsigned ? {16'd0, halfSel} : {{16{halfSel[15]}}, halfSel};
            default: ldData = rdWord;
        endcase
    end

endmodule

// File: rtl/data_memory_be.sv
// MEM-stage data memory with byte enables, sub-word loads, configurable read
// latency, post-reset zero-fill sweep and registered fault pulses.
module data_memory_be
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 2048,
    parameter int READ_LAT    = 1,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] address,
    input  logic [1:0]        size,
    input  logic              ld_unsigned,
    input  logic [31:0]       DataToWrite,
    output logic [31:0]       ReadData,
    output logic              rd_valid,
    output logic              ready,
    output logic              fault,
    output logic [1:0]        fault_code
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]   mem [DEPTH_WORDS];
    logic [0:0]    state;
    logic [AW-1:0] fillPtr;

    logic [AW-1:0] wordIdx;
    logic [1:0]    lane;
    logic          outOfRange, misaligned, conflict, running;
    logic          doLoad, doStore, reqFault;
    logic [1:0]    faultNext;
    logic [3:0]    byteEn;
    logic [31:0]   wrRep, ldData, rdWord;

    logic          memWe;
    logic [AW-1:0] memIdx;
    logic [3:0]    memBe;
    logic [31:0]   memData;

    assign wordIdx = address[AW+1:2];
    assign lane    = address[1:0];

    generate
        if (ADDR_W > AW + 2) begin : gRange
            assign outOfRange = |address[ADDR_W-1:AW+2];
        end else begin : gNoRange
            assign outOfRange = 1'b0;
        end
    endgenerate

    assign running    = (state == ST_RUN);
    assign ready      = running;
    assign conflict   = MemRead & MemWrite;
    assign misaligned = isMisaligned(size, lane);
    assign doLoad     = running & MemRead  & ~MemWrite & ~misaligned & ~outOfRange;
    assign doStore    = running & MemWrite & ~MemRead  & ~misaligned & ~outOfRange;

    always_comb begin
        faultNext = FC_NONE;
        if (conflict)        faultNext = FC_CONFLICT;
        else if (misaligned) faultNext = FC_MISALIGN;
        else if (outOfRange) faultNext = FC_RANGE;
    end
    assign reqFault = running & (MemRead | MemWrite) & (faultNext != FC_NONE);

    dmem_lane_align uAlign (
        .accSize    (size),
        .lane       (lane),
        .ldUnsigned (ld_unsigned),
        .wrData     (DataToWrite),
        .rdWord     (rdWord),
        .byteEn     (byteEn),
        .wrRep      (wrRep),
        .ldData     (ldData)
    );

    // The zero-fill sweep owns the write port until RUN.
    always_comb begin
        memWe   = doStore;
        memIdx  = wordIdx;
        memBe   = byteEn;
        memData = wrRep;
        if (!running) begin
            memWe   = 1'b1;
            memIdx  = fillPtr;
            memBe   = 4'b1111;
            memData = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (memWe) begin
            for (int b = 0; b < 4; b++) begin
                if (memBe[b]) mem[memIdx][8*b +: 8] <= memData[8*b +: 8];
            end
        end
    end

    assign rdWord = mem[wordIdx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_INIT;
            fillPtr <= '0;
        end else if (state == ST_INIT) begin
            fillPtr <= fillPtr + 1'b1;
            if (fillPtr == AW'(DEPTH_WORDS - 1)) state <= ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault      <= 1'b0;
            fault_code <= FC_NONE;
        end else begin
            fault      <= reqFault;
            fault_code <= reqFault ? faultNext : FC_NONE;
        end
    end

    // Read pipe: data of a stage only moves when its valid does, so the
    // output word holds between pulses.
    logic [READ_LAT-1:0] validPipe;
    logic [31:0]         dataPipe [READ_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            validPipe[0] <= 1'b0;
            dataPipe[0]  <= 32'd0;
        end else begin
            validPipe[0] <= doLoad;
            if (doLoad) dataPipe[0] <= ldData;
        end
    end

    generate
        for (genvar gi = 1; gi < READ_LAT; gi++) begin : gPipe
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    validPipe[gi] <= 1'b0;
                    dataPipe[gi]  <= 32'd0;
                end else begin
                    validPipe[gi] <= validPipe[gi-1];
                    if (validPipe[gi-1]) dataPipe[gi] <= dataPipe[gi-1];
                end
            end
        end
    endgenerate

    assign rd_valid = validPipe[READ_LAT-1];
    assign ReadData = dataPipe[READ_LAT-1];

endmodule
